// File: rtl/audio_pkg.sv
// Shared constants and FSM state type for the audio DAC serializer.
// Holds default sample width, FIFO depth and the DAC state enum.
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH = 32;
    localparam int AUDIO_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LEFT,
        RIGHT
    } dac_state_e;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample push bus between an audio producer and the DAC serializer.
// Ports: left/right samples, write strobe, flush request, not-full flag.
interface audio_dac_serializer_if
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] left_channel_audio_out;
    logic [DATA_WIDTH-1:0] right_channel_audio_out;
    logic                  write_audio_out;
    logic                  clear_audio_out_memory;
    logic                  audio_out_allowed;

    modport master (
        output left_channel_audio_out,
        output right_channel_audio_out,
        output write_audio_out,
        output clear_audio_out_memory,
        input  audio_out_allowed
    );

    modport slave (
        input  left_channel_audio_out,
        input  right_channel_audio_out,
        input  write_audio_out,
        input  clear_audio_out_memory,
        output audio_out_allowed
    );

endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo-frame FIFO with flush.
// Ports: clk/rst_n, clr, push/push_data, pop/pop_data, full, empty, level.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = 2 * AUDIO_DATA_WIDTH,
    parameter int DEPTH = AUDIO_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;

    // Pointers carry one extra wrap bit so full and empty differ.
    assign level    = wr_q - rd_q;
    assign empty    = (wr_q == rd_q);
    assign full     = (level == (AW + 1)'(DEPTH));
    assign pop_data = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (clr) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_q[AW-1:0]] = push_data;
                wr_d = wr_q + (AW + 1)'(1);
            end
            if (pop && !empty) begin
                rd_d = rd_q + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: buffers stereo frames and shifts them out MSB first.
// Ports: CLOCK_50/resetn, push bus, AUD_BCLK/AUD_DACLRCK in, AUD_DACDAT,
//        underflow/overflow pulses, fifo_level.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    audio_dac_serializer_if.slave        aud_if,
    input  logic                         AUD_BCLK,
    input  logic                         AUD_DACLRCK,
    output logic                         AUD_DACDAT,
    output logic                         underflow,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int FW = 2 * DATA_WIDTH;

    logic [2:0]            bclk_sync_q, bclk_sync_d;
    logic [2:0]            lrck_sync_q, lrck_sync_d;
    dac_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] right_hold_q, right_hold_d;
    logic [CW-1:0]         bits_left_q, bits_left_d;
    logic                  dacdat_q, dacdat_d;
    logic                  underflow_q, underflow_d;
    logic                  overflow_q, overflow_d;

    logic                  bclk_fall;
    logic                  lrck_fall;
    logic                  lrck_rise;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FW-1:0]         fifo_rd_data;

    // Bits 0/1 synchronize, bit 2 is the delayed copy for edge detect.
    always_comb begin
        bclk_sync_d = {bclk_sync_q[1:0], AUD_BCLK};
        lrck_sync_d = {lrck_sync_q[1:0], AUD_DACLRCK};
    end

    assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
    assign lrck_fall = lrck_sync_q[2] & ~lrck_sync_q[1];
    assign lrck_rise = ~lrck_sync_q[2] & lrck_sync_q[1];
    assign fifo_pop  = lrck_fall & ~fifo_empty;

    audio_sample_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .clr       (aud_if.clear_audio_out_memory),
        .push      (aud_if.write_audio_out),
        .push_data ({aud_if.left_channel_audio_out,
                     aud_if.right_channel_audio_out}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        right_hold_d = right_hold_q;
        bits_left_d  = bits_left_q;
        dacdat_d     = dacdat_q;
        underflow_d  = 1'b0;
        overflow_d   = aud_if.write_audio_out & fifo_full;

        // Output moves only on BCLK falls; a coincident LRCK edge still
        // lets the old word's last bit out before the reload below.
        if (bclk_fall) begin
            if (bits_left_q != '0) begin
                dacdat_d    = shift_q[DATA_WIDTH-1];
                shift_d     = {shift_q[DATA_WIDTH-2:0], 1'b0};
                bits_left_d = bits_left_q - CW'(1);
            end else begin
                dacdat_d = 1'b0;
            end
        end

        if (lrck_fall) begin
            if (fifo_empty) begin
                shift_d      = '0;
                right_hold_d = '0;
                underflow_d  = 1'b1;
            end else begin
                shift_d      = fifo_rd_data[FW-1:DATA_WIDTH];
                right_hold_d = fifo_rd_data[DATA_WIDTH-1:0];
            end
            bits_left_d = CW'(DATA_WIDTH);
            state_d     = LEFT;
        end else if (lrck_rise && state_q != WAIT_SYNC) begin
            shift_d     = right_hold_q;
            bits_left_d = CW'(DATA_WIDTH);
            state_d     = RIGHT;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            state_q      <= WAIT_SYNC;
            shift_q      <= '0;
            right_hold_q <= '0;
            bits_left_q  <= '0;
            dacdat_q     <= 1'b0;
            underflow_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            bclk_sync_q  <= bclk_sync_d;
            lrck_sync_q  <= lrck_sync_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            right_hold_q <= right_hold_d;
            bits_left_q  <= bits_left_d;
            dacdat_q     <= dacdat_d;
            underflow_q  <= underflow_d;
            overflow_q   <= overflow_d;
        end
    end

    assign AUD_DACDAT               = dacdat_q;
    assign underflow                = underflow_q;
    assign overflow                 = overflow_q;
    assign aud_if.audio_out_allowed = ~fifo_full;

endmodule
